dmem_responder: RTL and testbench

Data-memory responder for the MIPS core: the memory-side end of the load/store interface that the datapath drives with address, write data and read/write strobes. It accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, and returns read data or a write acknowledgement over a separate valid/ready response channel. Misaligned or out-of-range accesses are flagged rather than executed. It replaces the zero-latency data memory once the core is made stall-capable.

---
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with wait states, request/response handshakes and error flagging
`timescale 1ns/1ps

module dmem_responder #(
  parameter int          ADDR_WIDTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      cnt;
  logic            commit;

  logic            lat_write;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_be;

  logic            op_write;
  logic [31:0]     op_addr;
  logic [31:0]     op_wdata;
  logic [3:0]      op_be;
  logic [31:0]     off;
  logic            op_err;
  logic [ADDR_WIDTH-1:0] idx;

  logic [31:0]     mem [DEPTH];

  // With zero wait states the commit happens on the acceptance edge itself,
  // so the operands come straight from the request inputs in that case.
  always_comb begin
    op_write = lat_write;
    op_addr  = lat_addr;
    op_wdata = lat_wdata;
    op_be    = lat_be;
    if (state == S_IDLE) begin
      op_write = req_write;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_be    = req_be;
    end
  end

  // Word index and error decode; addresses below the base wrap to huge offsets and fail the range test.
  always_comb begin
    off    = op_addr - BASE_ADDR;
    idx    = off[ADDR_WIDTH+1:2];
    op_err = (op_addr[1:0] != 2'b00) || ((off >> (ADDR_WIDTH + 2)) != 32'd0);
  end

  // Next-state logic and commit strobe for the edge that enters RESP.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
            commit     = 1'b1;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = S_RESP;
          commit     = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs are forced low during reset so no transfer can be seen while rst is high.
  always_comb begin
    req_ready  = (state == S_IDLE) && !rst;
    resp_valid = (state == S_RESP) && !rst;
  end

  // State register, request latch, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_be     <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && req_valid) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        cnt       <= WAIT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        if (op_err) begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b1;
        end else if (op_write) begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
        end else begin
          resp_rdata <= mem[idx];
          resp_err   <= 1'b0;
        end
      end
    end
  end

  // Storage array: cleared on reset, byte-masked store on commit of a legal write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (commit && op_write && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (op_be[b]) begin
          mem[idx][8*b +: 8] <= op_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder against a behavioural memory model
`timescale 1ns/1ps

module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_be     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int          n_vec;
  int          n_bad;

  logic [31:0] base_of [2];
  int          wc_of   [2];
  logic [31:0] model_mem [2][256];

  // instance 0: defaults; instance 1: base 0x100, no wait states
  dmem_responder #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0000_0100), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 256; i++)
        model_mem[u][i] = 32'd0;
  endfunction

  // Reference: word memory of 256 entries per instance, error if misaligned or offset >= 1024 bytes.
  function automatic void model_op(input int u, input bit w, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [3:0] be,
                                   output logic [31:0] rd, output logic er);
    logic [31:0] off;
    off = a - base_of[u];
    er  = ((a % 4) != 0) || (off >= 32'd1024);
    rd  = 32'd0;
    if (!er) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[u][off / 4][8*b +: 8] = wd[8*b +: 8];
      end else begin
        rd = model_mem[u][off / 4];
      end
    end
  endfunction

  task automatic transact(input int u, input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input int hold);
    logic [31:0] erd;
    logic        eer;
    int          lat;
    model_op(u, w, a, wd, be, erd, eer);
    @(negedge clk);
    check_val("acc_ready", {31'd0, req_ready[u]}, 32'd1);
    req_valid[u] = 1'b1;
    req_write[u] = w;
    req_addr[u]  = a;
    req_wdata[u] = wd;
    req_be[u]    = be;
    @(negedge clk);
    req_valid[u] = 1'b0;
    req_write[u] = 1'($urandom);
    req_addr[u]  = $urandom;
    req_wdata[u] = $urandom;
    req_be[u]    = 4'($urandom);
    lat = 1;
    while (!resp_valid[u] && lat < 40) begin
      check_val("wait_ready", {31'd0, req_ready[u]}, 32'd0);
      @(negedge clk);
      lat++;
    end
    check_val("latency", lat, wc_of[u] + 1);
    for (int h = 0; h < hold; h++) begin
      check_val("hold_valid", {31'd0, resp_valid[u]}, 32'd1);
      check_val("hold_rdata", resp_rdata[u], erd);
      check_val("hold_err", {31'd0, resp_err[u]}, {31'd0, eer});
      check_val("hold_ready", {31'd0, req_ready[u]}, 32'd0);
      @(negedge clk);
    end
    check_val("rdata", resp_rdata[u], erd);
    check_val("err", {31'd0, resp_err[u]}, {31'd0, eer});
    resp_ready[u] = 1'b1;
    @(negedge clk);
    resp_ready[u] = 1'b0;
    check_val("post_valid", {31'd0, resp_valid[u]}, 32'd0);
    check_val("post_ready", {31'd0, req_ready[u]}, 32'd1);
  endtask

  function automatic logic [31:0] rand_addr(input int u);
    logic [31:0] b;
    b = base_of[u];
    case ($urandom_range(0, 5))
      0, 1, 2: return b + 4 * $urandom_range(0, 15);
      3:       return b + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      4:       return b + 32'd1024 + 4 * $urandom_range(0, 7);
      default: return b - 4 * $urandom_range(1, 4);
    endcase
  endfunction

  initial begin
    logic [31:0] exp_q [4];
    logic        dummy_err;
    int          k_acc, k_resp, cyc;
    bit          acc, rsp;

    n_vec = 0;
    n_bad = 0;
    base_of[0] = 32'h0000_0000; wc_of[0] = 2;
    base_of[1] = 32'h0000_0100; wc_of[1] = 0;
    model_clear();
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_write[u] = 1'b0; req_addr[u] = 32'd0;
      req_wdata[u] = 32'd0; req_be[u] = 4'd0; resp_ready[u] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_val("rst_req_ready", {31'd0, req_ready[u]}, 32'd0);
      check_val("rst_resp_valid", {31'd0, resp_valid[u]}, 32'd0);
      check_val("rst_rdata", resp_rdata[u], 32'd0);
      check_val("rst_err", {31'd0, resp_err[u]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_val("first_ready", {31'd0, req_ready[0]}, 32'd1);

    // directed scenarios
    transact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    transact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    transact(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0);
    transact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    transact(0, 1'b0, 32'h12, 32'h0, 4'h0, 0);
    transact(0, 1'b1, 32'h400, 32'hCAFE_F00D, 4'hF, 0);
    transact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    transact(0, 1'b1, 32'h14, 32'h5555_AAAA, 4'b0000, 0);
    transact(0, 1'b0, 32'h14, 32'h0, 4'h0, 5);
    transact(1, 1'b0, 32'h0FC, 32'h0, 4'h0, 0);
    transact(1, 1'b1, 32'h3FC, 32'h1234_5678, 4'hF, 0);
    transact(1, 1'b0, 32'h4FC, 32'h0, 4'h0, 2);

    // randomized traffic on both instances
    for (int n = 0; n < 60; n++) begin
      int u;
      u = n % 2;
      transact(u, 1'($urandom), rand_addr(u), $urandom, 4'($urandom), $urandom_range(0, 3));
    end

    // reset while a store sits in WAIT
    transact(0, 1'b1, 32'h20, 32'h0BAD_0BAD, 4'hF, 0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
    req_wdata[0] = 32'hFFFF_FFFF; req_be[0] = 4'hF;
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    check_val("midrst_ready_now", {31'd0, req_ready[0]}, 32'd0);
    @(negedge clk);
    check_val("midrst_valid", {31'd0, resp_valid[0]}, 32'd0);
    check_val("midrst_ready", {31'd0, req_ready[0]}, 32'd0);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    check_val("midrst_release_ready", {31'd0, req_ready[0]}, 32'd1);
    transact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);

    // zero-wait back-to-back loads with resp_ready held high
    for (int k = 0; k < 4; k++)
      transact(1, 1'b1, 32'h100 + 4 * k, $urandom, 4'hF, 0);
    for (int k = 0; k < 4; k++)
      model_op(1, 1'b0, 32'h100 + 4 * k, 32'd0, 4'd0, exp_q[k], dummy_err);
    @(negedge clk);
    resp_ready[1] = 1'b1;
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h100;
    k_acc = 0; k_resp = 0; cyc = 0;
    for (int t = 0; t < 30 && k_resp < 4; t++) begin
      acc = req_valid[1] && req_ready[1];
      rsp = resp_valid[1];
      if (acc || k_acc > 0) cyc++;
      if (rsp) begin
        check_val("b2b_rdata", resp_rdata[1], exp_q[k_resp]);
        check_val("b2b_err", {31'd0, resp_err[1]}, 32'd0);
        k_resp++;
      end
      if (acc) k_acc++;
      @(negedge clk);
      if (acc) begin
        if (k_acc < 4) req_addr[1] = 32'h100 + 4 * k_acc;
        else req_valid[1] = 1'b0;
      end
    end
    req_valid[1] = 1'b0;
    resp_ready[1] = 1'b0;
    check_val("b2b_responses", k_resp, 32'd4);
    check_val("b2b_cycles", cyc, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
